seq_mult_32: RTL and testbench
==============================

Name: seq_mult_32

Overview:
- Sequential 32x32 -> 64-bit shift-add multiplier.
- Internally split into an FSM control unit and a datapath unit (product register, multiplicand register, adder, iteration counter).
- Processes one multiplier bit per clock.
- Used as the multiply unit of the ALU; results go out on hi/lo, and a one-cycle stop pulse marks completion.

Parameters:
- WIDTH, 32, operand width. hi/lo are each WIDTH bits. The counter is clog2(WIDTH)+1 bits. Only 32 is required to be verified.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
- start  input  1  request a new multiply; sampled only in IDLE
- multiplicant  input  32  multiplicand operand, captured on accepted start
- multipliar  input  32  multiplier operand, captured on accepted start
- hi  output  32  upper half of product register
- lo  output  32  lower half of product register
- stop  output  1  completion pulse, high for exactly one cycle

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=IDLE; product register {hi,lo}=0; multiplicand register=0; counter=0; stop=0.
  - Reset has priority over every other event, including mid-operation; any operation in progress is aborted.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If start=1 at an edge: load {hi,lo}={32'h0, multipliar}, load the multiplicand register from multiplicant, counter=0, go to RUN.
  - Otherwise hold; hi/lo keep the last result.
- RUN, one edge per iteration:
  - If lo[0]=1, sum = {1'b0,hi} + {1'b0,mcand} (33-bit, carry kept). Else sum = {1'b0,hi}.
  - {hi,lo} <= {sum,lo} >> 1, i.e. the 65-bit value shifted right with the carry entering hi[31].
  - counter <= counter+1.
  - On the edge where counter==31 (the 32nd iteration), go to DONE.
- DONE:
  - stop=1 for this single cycle; hi/lo hold the final 64-bit product.
  - Next edge goes to IDLE unconditionally.
  - A start that is high during DONE is not accepted; it is accepted only if still high in IDLE.
- Timing: start accepted at edge k gives iteration edges k+1..k+32, with stop high in the cycle after edge k+32.
  - Latency is 32 cycles from the accepting edge to the stop cycle.
  - Back-to-back throughput: one product per 34 cycles.
- stop is registered (it decodes the DONE state). No combinational path from inputs to outputs.
- start is ignored in RUN and DONE; operand inputs may change freely after acceptance.
- Arithmetic: unsigned, exact 64-bit result, no overflow possible.
- hi/lo are visible during RUN as partial products. Their intermediate values are not part of the contract; only the values in the stop cycle and afterwards are.
- Leaving start high continuously restarts a new multiply each time IDLE is reached, reusing the current operand inputs.

Optional Feature:
- Macro MULT_SIGNED_EN.
- Defined: operands are treated as two's complement.
  - On accept, the datapath loads the magnitude of each operand and records sign = multipliar[31] ^ multiplicant[31].
  - In DONE, the product is the 64-bit two's-complement negation of the magnitude product when sign=1.
  - The negation is applied on the RUN->DONE edge, so latency is unchanged.
  - Magnitude of 0x80000000 is 0x80000000 treated as unsigned; the result is still exact.
- Undefined: pure unsigned behaviour as above; no sign logic is synthesised.

Test Plan:
- Reset, then start with multipliar=3, multiplicant=5 -> stop high exactly 32 cycles after the accepting edge, {hi,lo}=0x00000000_0000000F; stop low on the next cycle.
- multipliar=0xFFFFFFFF, multiplicant=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 (carry path exercised).
- multipliar=0x12345678, multiplicant=0 and vice versa -> hi=0, lo=0; then 0x80000000 x 2 -> hi=0x00000001, lo=0x00000000.
- Pulse start again mid-RUN with different operands -> ignored; first result delivered unchanged; only one stop pulse.
- Assert rst_n=0 for one edge at iteration 10 -> hi=lo=0, stop=0, state IDLE; a new start then produces a correct product (7x9=63).
- MULT_SIGNED_EN defined: -2 (0xFFFFFFFE) x 3 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA; -1 x -1 -> hi=0, lo=1. Same stimulus without the macro -> unsigned products.

Source files
------------

// File: rtl/seq_mult_32_if.sv
// Operand/result bundle for the sequential multiplier.
// The master drives start and the operands; the slave returns hi/lo and the stop pulse.
interface seq_mult_32_if #(parameter int WIDTH = 32);
  logic             start;
  logic [WIDTH-1:0] multiplicant;
  logic [WIDTH-1:0] multipliar;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             stop;

  modport master (output start, multiplicant, multipliar, input hi, lo, stop);
  modport slave  (input start, multiplicant, multipliar, output hi, lo, stop);
endinterface

// File: rtl/seq_mult_32.sv
// Shift-add WIDTHxWIDTH multiplier that retires one multiplier bit per clock and pulses stop when done.
// Define MULT_SIGNED_EN to treat both operands as two's complement (default: unsigned).
module seq_mult_32 #(
  parameter int WIDTH = 32
) (
  input logic         clk,
  input logic         rst_n,
  seq_mult_32_if.slave bus
);

  localparam int            CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  logic [CW-1:0]      count;
  logic               stop_q;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] shifted;
  logic [2*WIDTH-1:0] final_prod;
  logic [WIDTH-1:0]   load_mcand;
  logic [WIDTH-1:0]   load_mplier;
  logic               accept;
  logic               last_iter;

  assign accept    = (state == IDLE) && bus.start;
  assign last_iter = (state == RUN) && (count == LAST);

`ifdef MULT_SIGNED_EN
  logic sign;

  // Work on magnitudes; 0x80000000 negates to itself, which is the correct unsigned magnitude.
  assign load_mcand  = bus.multiplicant[WIDTH-1] ? -bus.multiplicant : bus.multiplicant;
  assign load_mplier = bus.multipliar[WIDTH-1]   ? -bus.multipliar   : bus.multipliar;
  assign final_prod  = sign ? -shifted : shifted;

  always_ff @(posedge clk) begin
    if (!rst_n)
      sign <= 1'b0;
    else if (accept)
      sign <= bus.multiplicant[WIDTH-1] ^ bus.multipliar[WIDTH-1];
  end
`else
  assign load_mcand  = bus.multiplicant;
  assign load_mplier = bus.multipliar;
  assign final_prod  = shifted;
`endif

  // One iteration: conditionally add the multiplicand into hi, keep the carry, shift all right by one.
  always_comb begin
    sum = {1'b0, prod[2*WIDTH-1:WIDTH]};
    if (prod[0])
      sum = sum + {1'b0, mcand};
    shifted = {sum, prod[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      count  <= '0;
      stop_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          stop_q <= 1'b0;
          if (accept) begin
            count <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          count <= count + 1'b1;
          if (last_iter) begin
            state  <= DONE;
            stop_q <= 1'b1;
          end
        end
        DONE: begin
          stop_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          stop_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  // The sign correction lands on the RUN->DONE edge, so it costs no extra cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prod  <= '0;
      mcand <= '0;
    end else if (accept) begin
      prod  <= {{WIDTH{1'b0}}, load_mplier};
      mcand <= load_mcand;
    end else if (state == RUN) begin
      prod <= last_iter ? final_prod : shifted;
    end
  end

  assign bus.hi   = prod[2*WIDTH-1:WIDTH];
  assign bus.lo   = prod[WIDTH-1:0];
  assign bus.stop = stop_q;

endmodule

// File: tb/tb_seq_mult_32.sv
// Self-checking bench for seq_mult_32: directed table, multi-cycle corner sequences, random vectors.
// Expected products come from plain 64-bit arithmetic (signed when MULT_SIGNED_EN is defined).
module tb_seq_mult_32;

  logic clk;
  logic rst_n;
  int   n_compared;
  int   n_mismatched;

  seq_mult_32_if #(.WIDTH(32)) bus ();

  seq_mult_32 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] simulation timed out");
  end

  typedef struct {
    logic [31:0] mc;
    logic [31:0] mp;
    logic [63:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [63:0] refProduct(input logic [31:0] mc, input logic [31:0] mp);
`ifdef MULT_SIGNED_EN
    longint sa;
    longint sb;
    sa = longint'($signed(mc));
    sb = longint'($signed(mp));
    return 64'(sa * sb);
`else
    return {32'h0, mc} * {32'h0, mp};
`endif
  endfunction

  task automatic applyStimulus(input logic s, input logic [31:0] mc, input logic [31:0] mp);
    bus.start        = s;
    bus.multiplicant = mc;
    bus.multipliar   = mp;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
    end
  endtask

  // Call with the DUT idle, just after a rising edge; returns just after the cycle following stop.
  task automatic runMult(input logic [31:0] mc, input logic [31:0] mp,
                         input logic [63:0] exp, input string name);
    int lat;
    bit seen;
    applyStimulus(1'b1, mc, mp);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, ~mc, ~mp);
    lat  = 0;
    seen = 1'b0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      @(posedge clk);
      #1;
      if (bus.stop) begin
        seen = 1'b1;
        lat  = c;
      end
    end
    checkOutput({name, " latency"}, 64'(lat), 64'd32);
    checkOutput({name, " product"}, {bus.hi, bus.lo}, exp);
    @(posedge clk);
    #1;
    checkOutput({name, " stop drop"}, {63'h0, bus.stop}, 64'h0);
    checkOutput({name, " product hold"}, {bus.hi, bus.lo}, exp);
  endtask

  initial begin
    int          pulses;
    int          first_at;
    int          second_at;
    logic [63:0] first_prod;
    logic [63:0] second_prod;
    logic [31:0] ra;
    logic [31:0] rb;

    n_compared   = 0;
    n_mismatched = 0;

    vecs[0] = '{32'd5,        32'd3,        64'h0000000000000000_F, "3x5"};
    vecs[3] = '{32'h12345678, 32'h0,        64'h0,                  "mcand x 0"};
    vecs[4] = '{32'h0,        32'h12345678, 64'h0,                  "0 x mplier"};
    vecs[6] = '{32'd7,        32'd9,        64'd63,                 "7x9"};
`ifdef MULT_SIGNED_EN
    vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0000000000000001,   "-1x-1"};
    vecs[2] = '{32'hFFFFFFFE, 32'd3,        64'hFFFFFFFFFFFFFFFA,   "-2x3"};
    vecs[5] = '{32'd2,        32'h80000000, 64'hFFFFFFFF00000000,   "minint x 2"};
`else
    vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001,   "max x max"};
    vecs[2] = '{32'hFFFFFFFE, 32'd3,        64'h00000002FFFFFFFA,   "fffffffe x 3"};
    vecs[5] = '{32'd2,        32'h80000000, 64'h0000000100000000,   "80000000 x 2"};
`endif
    vecs[7] = '{32'h80000000, 32'h80000000, 64'h4000000000000000,   "minint squared"};

    rst_n = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset product", {bus.hi, bus.lo}, 64'h0);
    checkOutput("reset stop", {63'h0, bus.stop}, 64'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++)
      runMult(vecs[i].mc, vecs[i].mp, vecs[i].exp, vecs[i].name);

    // A start pulse during RUN must not disturb the running product.
    applyStimulus(1'b1, 32'd11, 32'd13);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 32'd11, 32'd13);
    pulses     = 0;
    first_at   = 0;
    first_prod = '0;
    for (int c = 1; c <= 45; c++) begin
      @(posedge clk);
      #1;
      if (bus.stop) begin
        pulses++;
        if (pulses == 1) begin
          first_at   = c;
          first_prod = {bus.hi, bus.lo};
        end
      end
      if (c == 5)
        applyStimulus(1'b1, 32'hFFFF, 32'hFFFF);
      else if (c == 6)
        applyStimulus(1'b0, 32'h0, 32'h0);
    end
    checkOutput("midrun pulses", 64'(pulses), 64'd1);
    checkOutput("midrun latency", 64'(first_at), 64'd32);
    checkOutput("midrun product", first_prod, refProduct(32'd11, 32'd13));

    // Reset after ten iterations aborts the operation.
    applyStimulus(1'b1, 32'hDEADBEEF, 32'h12345679);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 32'h0, 32'h0);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("abort product", {bus.hi, bus.lo}, 64'h0);
    checkOutput("abort stop", {63'h0, bus.stop}, 64'h0);
    rst_n = 1'b1;
    runMult(32'd9, 32'd7, 64'd63, "after abort 7x9");

    // Holding start high restarts every 34 cycles with the current operands.
    applyStimulus(1'b1, 32'd6, 32'd7);
    @(posedge clk);
    pulses      = 0;
    first_at    = 0;
    second_at   = 0;
    first_prod  = '0;
    second_prod = '0;
    for (int c = 1; c <= 67; c++) begin
      @(posedge clk);
      #1;
      if (bus.stop) begin
        pulses++;
        if (pulses == 1) begin
          first_at   = c;
          first_prod = {bus.hi, bus.lo};
        end else if (pulses == 2) begin
          second_at   = c;
          second_prod = {bus.hi, bus.lo};
        end
      end
    end
    applyStimulus(1'b0, 32'h0, 32'h0);
    checkOutput("continuous pulses", 64'(pulses), 64'd2);
    checkOutput("continuous first at", 64'(first_at), 64'd32);
    checkOutput("continuous second at", 64'(second_at), 64'd66);
    checkOutput("continuous first product", first_prod, 64'd42);
    checkOutput("continuous second product", second_prod, 64'd42);
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 16; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i == 0) ra = 32'h80000000;
      if (i == 1) rb = 32'hFFFFFFFF;
      if (i == 2) ra = 32'h1;
      runMult(ra, rb, refProduct(ra, rb), $sformatf("random %0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
